can_transmitter: RTL

//  Serialises one CAN 2.0A standard data/remote frame into an unstuffed bitstream, one bit per tx_point strobe.

---
 rtl/can_transmitter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/can_transmitter.sv
// CAN 2.0A frame serialiser: SOF..IFS bitstream with internal CRC-15,
// arbitration-loss detection during ID/RTR and ACK-slot monitoring.
module can_transmitter #(
    parameter int MAX_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [10:0] tx_id_std,
    input  logic        tx_rtr,
    input  logic [3:0]  tx_dlc,
    input  logic [7:0]  tx_data [0:MAX_BYTES-1],
    input  logic        tx_point,
    input  logic        sample_point,
    input  logic        sampled_bit,
    output logic        tx_bit,
    output logic        stuff_en,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        arb_lost,
    output logic        ack_err
);
    localparam int DW = 8 * MAX_BYTES;
    localparam int CL = $clog2(DW + 1);
    localparam int CW = (CL > 4) ? CL : 4;

    // state names the field of the bit currently on tx_bit;
    // S_START holds recessive until the first tx_point
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_SOF, S_ID, S_RTR, S_IDE, S_R0,
        S_DLC, S_DATA, S_CRC, S_CRCD, S_ACK, S_ACKD,
        S_EOF, S_IFS
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   nb_q, nb_d;
    logic [10:0]     id_q, id_d;
    logic            rtr_q, rtr_d;
    logic [3:0]      dlc_q, dlc_d;
    logic [DW-1:0]   data_q, data_d;
    logic [14:0]     crc_q, crc_d;
    logic            bit_q, bit_d;
    logic            done_q, done_d;
    logic            arb_q, arb_d;
    logic            aerr_q, aerr_d;
    logic            ackf_q, ackf_d;

    state_t          nstate;
    logic [CW-1:0]   len;
    logic [CW-1:0]   nb_new;
    logic            nbit;
    logic            lost;

    function automatic logic [14:0] crc_step(
        input logic [14:0] c,
        input logic        b
    );
        logic [14:0] poly;
        poly = (b ^ c[14]) ? 15'h4599 : 15'h0000;
        return {c[13:0], 1'b0} ^ poly;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        id_d    = id_q;
        rtr_d   = rtr_q;
        dlc_d   = dlc_q;
        data_d  = data_q;
        crc_d   = crc_q;
        bit_d   = bit_q;
        ackf_d  = ackf_q;
        done_d  = 1'b0;
        arb_d   = 1'b0;
        aerr_d  = 1'b0;
        nstate  = state_q;
        nbit    = bit_q;
        lost    = 1'b0;

        nb_new = CW'(tx_dlc);
        if (nb_new > CW'(MAX_BYTES)) begin
            nb_new = CW'(MAX_BYTES);
        end
        if (tx_rtr) begin
            nb_new = '0;
        end

        unique case (state_q)
            S_ID:    len = CW'(11);
            S_DLC:   len = CW'(4);
            S_DATA:  len = nb_q << 3;
            S_CRC:   len = CW'(15);
            S_EOF:   len = CW'(7);
            S_IFS:   len = CW'(3);
            default: len = CW'(1);
        endcase

        if (state_q == S_IDLE) begin
            if (tx_start) begin
                id_d    = tx_id_std;
                rtr_d   = tx_rtr;
                dlc_d   = tx_dlc;
                nb_d    = nb_new;
                for (int i = 0; i < MAX_BYTES; i++) begin
                    data_d[DW-1-8*i -: 8] = tx_data[i];
                end
                crc_d   = '0;
                cnt_d   = '0;
                ackf_d  = 1'b0;
                bit_d   = 1'b1;
                state_d = S_START;
            end
        end else begin
            lost = sample_point && bit_q && !sampled_bit
                && (state_q == S_ID || state_q == S_RTR);
            if (sample_point && state_q == S_ACK
                && sampled_bit && !ackf_q) begin
                aerr_d = 1'b1;
                ackf_d = 1'b1;
            end

            // an arbitration loss wins over a coincident tx_point
            if (lost) begin
                arb_d   = 1'b1;
                state_d = S_IDLE;
                bit_d   = 1'b1;
                cnt_d   = '0;
            end else if (tx_point) begin
                if (cnt_q == len - CW'(1)) begin
                    cnt_d = '0;
                    unique case (state_q)
                        S_START: nstate = S_SOF;
                        S_SOF:   nstate = S_ID;
                        S_ID:    nstate = S_RTR;
                        S_RTR:   nstate = S_IDE;
                        S_IDE:   nstate = S_R0;
                        S_R0:    nstate = S_DLC;
                        S_DLC:   nstate = (nb_q == '0) ? S_CRC : S_DATA;
                        S_DATA:  nstate = S_CRC;
                        S_CRC:   nstate = S_CRCD;
                        S_CRCD:  nstate = S_ACK;
                        S_ACK:   nstate = S_ACKD;
                        S_ACKD:  nstate = S_EOF;
                        S_EOF:   nstate = S_IFS;
                        default: nstate = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end

                unique case (nstate)
                    S_SOF, S_IDE, S_R0: nbit = 1'b0;
                    S_ID: begin
                        nbit = id_q[10];
                        id_d = {id_q[9:0], 1'b0};
                    end
                    S_RTR: nbit = rtr_q;
                    S_DLC: begin
                        nbit  = dlc_q[3];
                        dlc_d = {dlc_q[2:0], 1'b0};
                    end
                    S_DATA: begin
                        nbit   = data_q[DW-1];
                        data_d = {data_q[DW-2:0], 1'b0};
                    end
                    S_CRC: begin
                        nbit  = crc_q[14];
                        crc_d = {crc_q[13:0], 1'b0};
                    end
                    S_IDLE: begin
                        nbit   = 1'b1;
                        done_d = !ackf_q;
                    end
                    default: nbit = 1'b1;
                endcase

                if (nstate inside {[S_SOF:S_DATA]}) begin
                    crc_d = crc_step(crc_q, nbit);
                end
                state_d = nstate;
                bit_d   = nbit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nb_q    <= '0;
            id_q    <= '0;
            rtr_q   <= 1'b0;
            dlc_q   <= '0;
            data_q  <= '0;
            crc_q   <= '0;
            bit_q   <= 1'b1;
            done_q  <= 1'b0;
            arb_q   <= 1'b0;
            aerr_q  <= 1'b0;
            ackf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            id_q    <= id_d;
            rtr_q   <= rtr_d;
            dlc_q   <= dlc_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            arb_q   <= arb_d;
            aerr_q  <= aerr_d;
            ackf_q  <= ackf_d;
        end
    end

    assign tx_bit   = bit_q;
    assign stuff_en = state_q inside {[S_SOF:S_CRC]};
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_done  = done_q;
    assign arb_lost = arb_q;
    assign ack_err  = aerr_q;

endmodule
